filter_dist_ctrl: RTL and testbench



---
 rtl/filter_dist_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_filter_dist_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_dist_ctrl.sv
// filter_dist_ctrl: loads a DEPTH_F x DEPTH_F byte filter into a row-packed
// buffer, then sends one filter row per PE as an XY-routed NoC packet over
// a valid/ready handshake.
// Optional build macro FILTER_DIST_PARITY_EN: pkt_data[56] carries even parity
// over pkt_data[55:0]; when undefined bit 56 is constant 0.
module filter_dist_ctrl #(
   parameter int unsigned WIDTH_addr = 12,
   parameter int unsigned WIDTH_data = 8,
   parameter int unsigned DEPTH_F    = 5,
   parameter int unsigned NODE       = 11,
   parameter int unsigned MESH_X     = 5,
   parameter int unsigned SEND_GAP   = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ld_start,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [WIDTH_addr-1:0] wr_addr,
   input  logic [WIDTH_data-1:0] wr_data,
   input  logic                  ld_done,
   output logic                  pkt_valid,
   input  logic                  pkt_ready,
   output logic [56:0]           pkt_data,
   output logic                  busy,
   output logic                  dist_done,
   output logic                  load_err
);

   localparam int unsigned NCELL   = DEPTH_F * DEPTH_F;
   localparam int unsigned ROW_W   = DEPTH_F * WIDTH_data;
   localparam int unsigned IDX_W   = (DEPTH_F > 1) ? $clog2(DEPTH_F) : 1;
   localparam int unsigned CELL_W  = (NCELL > 1) ? $clog2(NCELL) : 1;
   localparam int unsigned GAP_W   = (SEND_GAP > 1) ? $clog2(SEND_GAP) : 1;
   localparam int unsigned SRC     = NODE - 1;
   localparam int unsigned SRC_COL = SRC % MESH_X;
   localparam int unsigned SRC_ROW = SRC / MESH_X;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      BUILD = 3'd2,
      SEND  = 3'd3,
      GAP   = 3'd4
   } state_t;

   state_t             state;
   logic [ROW_W-1:0]   buf_q [DEPTH_F];
   logic [NCELL-1:0]   bitmap_q;
   logic [IDX_W-1:0]   idx_q;
   logic [GAP_W-1:0]   gap_cnt;

   logic               addr_ok;
   logic               wr_en;
   logic [IDX_W-1:0]   wr_row;
   logic [IDX_W-1:0]   wr_byte;
   logic [NCELL-1:0]   bitmap_nxt;
   logic [56:0]        pkt_nxt;
   logic [3:0]         dcol, drow, scol, srow;
   int unsigned        dst;

   // Decode the load write and fold it into the bitmap seen by ld_done
   always_comb begin
      addr_ok    = 32'(wr_addr) < NCELL;
      wr_en      = (state == LOAD) && wr_valid && addr_ok;
      wr_row     = IDX_W'(32'(wr_addr) / DEPTH_F);
      wr_byte    = IDX_W'(32'(wr_addr) % DEPTH_F);
      bitmap_nxt = bitmap_q;
      if (wr_en) begin
         bitmap_nxt[CELL_W'(wr_addr)] = 1'b1;
      end
   end

   // Assemble the packet for the current destination row
   always_comb begin
      dst     = 32'(idx_q);
      dcol    = 4'(dst % MESH_X);
      drow    = 4'(dst / MESH_X);
      scol    = 4'(SRC_COL);
      srow    = 4'(SRC_ROW);
      pkt_nxt = '0;
      pkt_nxt[39:0]  = 40'(buf_q[idx_q]);
      pkt_nxt[55:52] = 4'(SRC) + 4'd1;
      pkt_nxt[51:48] = 4'(idx_q) + 4'd1;
      pkt_nxt[47]    = dcol > scol;
      pkt_nxt[46:44] = 3'((dcol > scol) ? (dcol - scol) : (scol - dcol));
      pkt_nxt[43]    = drow > srow;
      pkt_nxt[42:40] = 3'((drow > srow) ? (drow - srow) : (srow - drow));
`ifdef FILTER_DIST_PARITY_EN
      pkt_nxt[56]    = ^pkt_nxt[55:0];
`else
      pkt_nxt[56]    = 1'b0;
`endif
   end

   // Control FSM with registered outputs, row buffer and write bitmap
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         bitmap_q  <= '0;
         idx_q     <= '0;
         gap_cnt   <= '0;
         wr_ready  <= 1'b0;
         pkt_valid <= 1'b0;
         pkt_data  <= '0;
         busy      <= 1'b0;
         dist_done <= 1'b0;
         load_err  <= 1'b0;
         for (int unsigned r = 0; r < DEPTH_F; r++) begin
            buf_q[r] <= '0;
         end
      end else begin
         dist_done <= 1'b0;
         case (state)
            IDLE: begin
               if (ld_start) begin
                  state    <= LOAD;
                  bitmap_q <= '0;
                  load_err <= 1'b0;
                  wr_ready <= 1'b1;
                  busy     <= 1'b1;
                  // Clearing the rows keeps unwritten bytes at 0 on every load
                  for (int unsigned r = 0; r < DEPTH_F; r++) begin
                     buf_q[r] <= '0;
                  end
               end
            end
            LOAD: begin
               bitmap_q <= bitmap_nxt;
               if (wr_en) begin
                  for (int unsigned b = 0; b < DEPTH_F; b++) begin
                     if (wr_byte == IDX_W'(b)) begin
                        buf_q[wr_row][b*WIDTH_data +: WIDTH_data] <= wr_data;
                     end
                  end
               end else if (wr_valid) begin
                  load_err <= 1'b1;
               end
               if (ld_done) begin
                  if (!(&bitmap_nxt)) begin
                     load_err <= 1'b1;
                  end
                  state    <= BUILD;
                  wr_ready <= 1'b0;
                  idx_q    <= '0;
               end
            end
            BUILD: begin
               pkt_data  <= pkt_nxt;
               pkt_valid <= 1'b1;
               state     <= SEND;
            end
            SEND: begin
               if (pkt_ready) begin
                  pkt_valid <= 1'b0;
                  gap_cnt   <= '0;
                  if (idx_q == IDX_W'(DEPTH_F - 1)) begin
                     dist_done <= 1'b1;
                     busy      <= 1'b0;
                     state     <= IDLE;
                  end else begin
                     idx_q <= idx_q + IDX_W'(1);
                     state <= (SEND_GAP == 0) ? BUILD : GAP;
                  end
               end
            end
            GAP: begin
               if (gap_cnt == GAP_W'(SEND_GAP - 1)) begin
                  state <= BUILD;
               end else begin
                  gap_cnt <= gap_cnt + GAP_W'(1);
               end
            end
            default: begin
               state     <= IDLE;
               busy      <= 1'b0;
               wr_ready  <= 1'b0;
               pkt_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_filter_dist_ctrl.sv
// Directed bench for filter_dist_ctrl: one DUT at NODE=11 and one at NODE=3
// share all inputs so routing headers of both nodes can be checked together.
module tb_filter_dist_ctrl;

   logic        clk = 1'b0;
   logic        reset, ld_start, wr_valid, ld_done, pkt_ready;
   logic [11:0] wr_addr;
   logic [7:0]  wr_data;
   logic        a_wr_ready, a_pkt_valid, a_busy, a_dist_done, a_load_err;
   logic        b_wr_ready, b_pkt_valid, b_busy, b_dist_done, b_load_err;
   logic [56:0] a_pkt_data, b_pkt_data;

   int errs = 0;
   int checks = 0;
   logic [56:0] got_a [5];
   logic [56:0] got_b [5];
   int          acc_cyc [5];
   int          got_n, done_n;

   always #5 clk = ~clk;

   filter_dist_ctrl #(.NODE(11)) dut_a (
      .clk(clk), .reset(reset), .ld_start(ld_start), .wr_valid(wr_valid),
      .wr_ready(a_wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .ld_done(ld_done), .pkt_valid(a_pkt_valid), .pkt_ready(pkt_ready),
      .pkt_data(a_pkt_data), .busy(a_busy), .dist_done(a_dist_done),
      .load_err(a_load_err)
   );

   filter_dist_ctrl #(.NODE(3)) dut_b (
      .clk(clk), .reset(reset), .ld_start(ld_start), .wr_valid(wr_valid),
      .wr_ready(b_wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .ld_done(ld_done), .pkt_valid(b_pkt_valid), .pkt_ready(pkt_ready),
      .pkt_data(b_pkt_data), .busy(b_busy), .dist_done(b_dist_done),
      .load_err(b_load_err)
   );

   // Expected bits 55:0 for NODE=11 (src col 0 row 2) with data = addr+1
   function automatic logic [55:0] exp11(input int k);
      logic [39:0] d;
      for (int b = 0; b < 5; b++) d[b*8 +: 8] = 8'(5*k + b + 1);
      return {4'hB, 4'(k + 1), (k > 0), 3'(k), 1'b0, 3'd2, d};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1; ld_start = 0; wr_valid = 0; ld_done = 0; pkt_ready = 0;
      wr_addr = '0; wr_data = '0;
      step(); step();
      reset = 0;
   endtask

   task automatic wr(input int a, input int d);
      wr_valid = 1; wr_addr = 12'(a); wr_data = 8'(d);
      step();
      wr_valid = 0;
   endtask

   task automatic start_load();
      ld_start = 1; step(); ld_start = 0;
   endtask

   task automatic finish_load();
      ld_done = 1; step(); ld_done = 0;
   endtask

   task automatic load_full();
      start_load();
      for (int a = 0; a < 25; a++) wr(a, a + 1);
      finish_load();
   endtask

   // Accept packets with ready held high; record data and acceptance cycle
   task automatic run_dist();
      got_n = 0; done_n = 0; pkt_ready = 1;
      for (int c = 0; c < 40; c++) begin
         if (a_pkt_valid && got_n < 5) begin
            got_a[got_n] = a_pkt_data; got_b[got_n] = b_pkt_data;
            acc_cyc[got_n] = c; got_n++;
         end
         step();
         if (a_dist_done) done_n++;
      end
      checks++;
      if (got_n !== 5) begin errs++; $display("FAIL pkt_count got %0d exp 5", got_n); end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({a_wr_ready, a_pkt_valid, a_busy, a_dist_done, a_load_err} !== 5'b0) begin
         errs++; $display("FAIL reset_flags got %b exp 00000",
                          {a_wr_ready, a_pkt_valid, a_busy, a_dist_done, a_load_err});
      end
      checks++;
      if (a_pkt_data !== 57'h0) begin errs++; $display("FAIL reset_pkt_data got %h exp 0", a_pkt_data); end
   endtask

   task automatic test_basic();
      logic [56:0] c0;
      c0 = 57'h0B1020504030201;
      start_load();
      checks++;
      if ({a_wr_ready, a_busy} !== 2'b11) begin errs++; $display("FAIL load_ready_busy got %b exp 11", {a_wr_ready, a_busy}); end
      for (int a = 0; a < 25; a++) wr(a, a + 1);
      finish_load();
      run_dist();
      checks++;
      if (got_a[0][55:0] !== c0[55:0]) begin errs++; $display("FAIL first_pkt got %h exp %h", got_a[0], c0); end
      for (int k = 1; k < 5; k++) begin
         checks++;
         if (got_a[k][55:0] !== exp11(k)) begin errs++; $display("FAIL pkt%0d got %h exp %h", k, got_a[k][55:0], exp11(k)); end
      end
      checks++;
      if (acc_cyc[0] !== 1) begin errs++; $display("FAIL first_valid_cycle got %0d exp 1", acc_cyc[0]); end
      for (int k = 1; k < 5; k++) begin
         checks++;
         if (acc_cyc[k] - acc_cyc[k-1] !== 4) begin
            errs++; $display("FAIL spacing%0d got %0d exp 4", k, acc_cyc[k] - acc_cyc[k-1]);
         end
      end
      checks++;
      if (done_n !== 1) begin errs++; $display("FAIL dist_done_count got %0d exp 1", done_n); end
      checks++;
      if ({a_load_err, a_busy} !== 2'b00) begin errs++; $display("FAIL end_err_busy got %b exp 00", {a_load_err, a_busy}); end
   endtask

   task automatic test_routing();
      checks++;
      if (got_b[0][47:40] !== 8'h20) begin errs++; $display("FAIL n3_dst0_hdr got %h exp 20", got_b[0][47:40]); end
      checks++;
      if (got_b[4][47:40] !== 8'hA0) begin errs++; $display("FAIL n3_dst4_hdr got %h exp a0", got_b[4][47:40]); end
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (got_b[k][55:52] !== 4'd3) begin errs++; $display("FAIL n3_src%0d got %0d exp 3", k, got_b[k][55:52]); end
      end
   endtask

   task automatic test_parity();
      logic ea, eb;
      for (int k = 0; k < 5; k++) begin
`ifdef FILTER_DIST_PARITY_EN
         ea = ^got_a[k][55:0]; eb = ^got_b[k][55:0];
`else
         ea = 1'b0; eb = 1'b0;
`endif
         checks++;
         if ({got_a[k][56], got_b[k][56]} !== {ea, eb}) begin
            errs++; $display("FAIL bit56_pkt%0d got %b exp %b", k, {got_a[k][56], got_b[k][56]}, {ea, eb});
         end
      end
   endtask

   task automatic test_backpressure();
      logic [56:0] held;
      int n;
      load_full();
      pkt_ready = 1;
      n = 0;
      while (!a_pkt_valid && n < 20) begin step(); n++; end
      step();
      pkt_ready = 0;
      n = 0;
      while (!a_pkt_valid && n < 20) begin step(); n++; end
      held = a_pkt_data;
      checks++;
      if (held[55:0] !== exp11(1)) begin errs++; $display("FAIL bp_pkt1 got %h exp %h", held[55:0], exp11(1)); end
      for (int c = 0; c < 10; c++) begin
         step();
         checks++;
         if (a_pkt_valid !== 1'b1 || a_pkt_data !== held) begin
            errs++; $display("FAIL bp_hold%0d got v=%b d=%h exp v=1 d=%h", c, a_pkt_valid, a_pkt_data, held);
         end
      end
      pkt_ready = 1;
      step();
      n = 0;
      while (!a_pkt_valid && n < 20) begin step(); n++; end
      checks++;
      if (n !== 3) begin errs++; $display("FAIL bp_next_gap got %0d exp 3", n); end
      checks++;
      if (a_pkt_data[55:0] !== exp11(2)) begin errs++; $display("FAIL bp_pkt2 got %h exp %h", a_pkt_data[55:0], exp11(2)); end
      do_reset();
   endtask

   task automatic test_load_errors();
      start_load();
      for (int a = 0; a < 25; a++) if (a != 17) wr(a, a + 1);
      finish_load();
      checks++;
      if (a_load_err !== 1'b1) begin errs++; $display("FAIL missing_err got %b exp 1", a_load_err); end
      run_dist();
      checks++;
      if (got_a[3][39:0] !== {8'd20, 8'd19, 8'd0, 8'd17, 8'd16}) begin
         errs++; $display("FAIL missing_byte got %h exp 1413001110", got_a[3][39:0]);
      end
      start_load();
      checks++;
      if (a_load_err !== 1'b0) begin errs++; $display("FAIL err_clear got %b exp 0", a_load_err); end
      wr(25, 8'h99);
      checks++;
      if (a_load_err !== 1'b1) begin errs++; $display("FAIL oob_err got %b exp 1", a_load_err); end
      for (int a = 0; a < 25; a++) wr(a, a + 1);
      finish_load();
      run_dist();
      checks++;
      if (got_a[4][55:0] !== exp11(4) || a_load_err !== 1'b1) begin
         errs++; $display("FAIL oob_dropped got %h err=%b exp %h err=1", got_a[4][55:0], a_load_err, exp11(4));
      end
   endtask

   task automatic test_corners();
      int bad;
      start_load();
      wr(0, 1);
      wr(0, 8'h77);
      for (int a = 1; a < 24; a++) wr(a, a + 1);
      wr_valid = 1; wr_addr = 12'd24; wr_data = 8'hEE; ld_done = 1;
      step();
      wr_valid = 0; ld_done = 0;
      checks++;
      if (a_load_err !== 1'b0) begin errs++; $display("FAIL same_cycle_err got %b exp 0", a_load_err); end
      run_dist();
      checks++;
      if (got_a[4][39:32] !== 8'hEE) begin errs++; $display("FAIL same_cycle_byte got %h exp ee", got_a[4][39:32]); end
      checks++;
      if (got_a[0][7:0] !== 8'h77) begin errs++; $display("FAIL dup_overwrite got %h exp 77", got_a[0][7:0]); end

      start_load();
      for (int a = 0; a < 25; a++) wr(a, a + 1);
      pkt_ready = 0;
      finish_load();
      step();
      ld_start = 1; step(); ld_start = 0;
      checks++;
      if ({a_pkt_valid, a_busy, a_wr_ready} !== 3'b110 || a_pkt_data[55:0] !== exp11(0)) begin
         errs++; $display("FAIL ld_start_in_send got v/b/r=%b d=%h exp 110 d=%h",
                          {a_pkt_valid, a_busy, a_wr_ready}, a_pkt_data[55:0], exp11(0));
      end
      reset = 1; step(); reset = 0;
      pkt_ready = 1;
      checks++;
      if ({a_pkt_valid, a_busy, a_dist_done} !== 3'b000) begin
         errs++; $display("FAIL reset_in_send got v/b/d=%b exp 000", {a_pkt_valid, a_busy, a_dist_done});
      end
      bad = 0;
      for (int c = 0; c < 6; c++) begin
         step();
         if (a_pkt_valid || a_dist_done) bad++;
      end
      checks++;
      if (bad !== 0) begin errs++; $display("FAIL after_reset_quiet got %0d active cycles exp 0", bad); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_routing();
      test_parity();
      test_backpressure();
      test_load_errors();
      test_corners();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
